// File: rtl/pong_pkg.sv
// pong_pkg: playfield geometry, FSM state type and small coordinate helpers shared by the engine
package pong_pkg;
  typedef logic signed [10:0] coord_t;
  typedef enum logic [1:0] {SERVE, PLAY, MISS, OVER} state_t;
  localparam int BOARD_W = 256;
  localparam int BALL_R  = 10;
  localparam coord_t PAD_LEN   = 11'sd48;
  localparam coord_t X_LO      = coord_t'(BALL_R);
  localparam coord_t X_HI      = coord_t'(BOARD_W - BALL_R);
  localparam coord_t Y_BOT_HIT = 11'sd20;
  localparam coord_t Y_TOP_HIT = 11'sd380;
  localparam coord_t Y_BOT_LIM = 11'sd0;
  localparam coord_t Y_TOP_LIM = 11'sd400;
  localparam coord_t PAD_MAX   = coord_t'(BOARD_W) - PAD_LEN;
  localparam coord_t ZONE_LO   = 11'sd16;
  localparam coord_t ZONE_HI   = 11'sd32;
  localparam logic [9:0] X_CTR     = 10'd128;
  localparam logic [8:0] Y_CTR     = 9'd200;
  localparam logic [9:0] PAD_CTR   = 10'd104;
  localparam logic [9:0] TICK_LINE = 10'd480;

  function automatic coord_t sx(input logic [9:0] v);
    return coord_t'({1'b0, v});
  endfunction

  function automatic logic [9:0] pad_next(input logic [9:0] p, input logic dec, input logic inc, input coord_t step);
    coord_t n;
    n = sx(p) + (dec == inc ? 11'sd0 : inc ? step : -step);
    return n[10] ? 10'd0 : n > PAD_MAX ? PAD_MAX[9:0] : n[9:0];
  endfunction

  function automatic logic on_pad(input logic [9:0] bx, input logic [9:0] pad);
    return sx(bx) >= sx(pad) && sx(bx) <= sx(pad) + PAD_LEN;
  endfunction

  // Where the ball lands on the paddle picks the outgoing horizontal speed
  function automatic logic signed [2:0] zone_dx(input logic [9:0] bx, input logic [9:0] pad, input logic neg);
    coord_t off;
    off = sx(bx) - sx(pad);
    return off < ZONE_LO ? -3'sd2 : off > ZONE_HI ? 3'sd2 : neg ? -3'sd1 : 3'sd1;
  endfunction
endpackage

// File: rtl/frame_tick.sv
// frame_tick: vertical-blank tick pulse and two-flop synchronisers for the five buttons
module frame_tick import pong_pkg::*; (
  input  logic        pixel_clock,
  input  logic        reset,
  input  logic [10:0] pixel_count0,
  input  logic [9:0]  line_count0,
  input  logic [4:0]  btn_async,
  output logic        tick,
  output logic [4:0]  btn_sync
);
  logic [4:0] meta_q, sync_q;
  assign tick = line_count0 == TICK_LINE && pixel_count0 == 11'd0;
  assign btn_sync = sync_q;
  always_ff @(posedge pixel_clock) begin
    if (!reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= btn_async;
      sync_q <= meta_q;
    end
  end
endmodule

// File: rtl/pong_engine.sv
// pong_engine: once-per-frame update of ball, paddles, bounces, misses and score
module pong_engine import pong_pkg::*; #(
  parameter int WIN_SCORE = 9,
  parameter int MISS_HOLD = 60,
  parameter int PAD_STEP  = 2
) (
  input  logic        pixel_clock,
  input  logic        reset,
  input  logic [10:0] pixel_count0,
  input  logic [9:0]  line_count0,
  input  logic        btn_up_l,
  input  logic        btn_up_r,
  input  logic        btn_dn_l,
  input  logic        btn_dn_r,
  input  logic        btn_serve,
  output logic [9:0]  ballx,
  output logic [8:0]  bally,
  output logic [9:0]  padup,
  output logic [9:0]  padwn,
  output logic [3:0]  score_up,
  output logic [3:0]  score_dn,
  output logic        game_over
);
  localparam int CW = $clog2(MISS_HOLD + 1);
  localparam coord_t STEP = coord_t'(PAD_STEP);
  logic tick;
  logic [4:0] btn;
  state_t state_q, state_d;
  logic [9:0] ballx_q, ballx_d, padup_q, padup_d, padwn_q, padwn_d;
  logic [8:0] bally_q, bally_d;
  logic [3:0] score_up_q, score_up_d, score_dn_q, score_dn_d;
  logic signed [2:0] dx_q, dx_d, dy_q, dy_d;
  logic [CW-1:0] miss_cnt_q, miss_cnt_d;
  logic game_over_q, game_over_d;
  coord_t nx, ny;
  logic bot_hit, top_hit, wall, won;

  frame_tick u_tick (
    .pixel_clock (pixel_clock),
    .reset       (reset),
    .pixel_count0(pixel_count0),
    .line_count0 (line_count0),
    .btn_async   ({btn_serve, btn_dn_r, btn_dn_l, btn_up_r, btn_up_l}),
    .tick        (tick),
    .btn_sync    (btn)
  );

  assign nx = sx(ballx_q) + coord_t'(dx_q);
  assign ny = sx({1'b0, bally_q}) + coord_t'(dy_q);
  assign wall = nx <= X_LO || nx >= X_HI;
  assign bot_hit = dy_q[2] && ny <= Y_BOT_HIT && sx({1'b0, bally_q}) > Y_BOT_HIT && on_pad(ballx_q, padwn_q);
  assign top_hit = !dy_q[2] && ny >= Y_TOP_HIT && sx({1'b0, bally_q}) < Y_TOP_HIT && on_pad(ballx_q, padup_q);
  assign won = score_up_q == 4'(WIN_SCORE) || score_dn_q == 4'(WIN_SCORE);

  always_comb begin
    state_d = state_q;
    ballx_d = ballx_q;
    bally_d = bally_q;
    padup_d = padup_q;
    padwn_d = padwn_q;
    score_up_d = score_up_q;
    score_dn_d = score_dn_q;
    dx_d = dx_q;
    dy_d = dy_q;
    miss_cnt_d = miss_cnt_q;
    if (tick) begin
      if (state_q != OVER) begin
        padup_d = pad_next(padup_q, btn[0], btn[1], STEP);
        padwn_d = pad_next(padwn_q, btn[2], btn[3], STEP);
      end
      case (state_q)
        SERVE: if (btn[4]) begin
          state_d = PLAY;
          dx_d = 3'sd1;
        end
        PLAY: begin
          ballx_d = nx <= X_LO ? X_LO[9:0] : nx >= X_HI ? X_HI[9:0] : nx[9:0];
          if (bot_hit || top_hit) begin
            bally_d = bot_hit ? Y_BOT_HIT[8:0] : Y_TOP_HIT[8:0];
            dy_d = -dy_q;
            dx_d = zone_dx(ballx_q, bot_hit ? padwn_q : padup_q, dx_q[2]);
          end else if (ny <= Y_BOT_LIM) begin
            bally_d = Y_BOT_LIM[8:0];
            score_up_d = score_up_q + 4'(score_up_q != 4'(WIN_SCORE));
            state_d = MISS;
          end else if (ny >= Y_TOP_LIM) begin
            bally_d = Y_TOP_LIM[8:0];
            score_dn_d = score_dn_q + 4'(score_dn_q != 4'(WIN_SCORE));
            state_d = MISS;
          end else
            bally_d = ny[8:0];
          // A side-wall reflection takes precedence over the paddle zone speed
          if (wall) dx_d = -dx_q;
        end
        MISS: begin
          miss_cnt_d = miss_cnt_q + 1'b1;
          if (miss_cnt_q == CW'(MISS_HOLD - 1)) begin
            miss_cnt_d = '0;
            state_d = won ? OVER : SERVE;
            ballx_d = won ? ballx_q : X_CTR;
            bally_d = won ? bally_q : Y_CTR;
          end
        end
        OVER: if (btn[4]) begin
          state_d = SERVE;
          score_up_d = '0;
          score_dn_d = '0;
          ballx_d = X_CTR;
          bally_d = Y_CTR;
          padup_d = PAD_CTR;
          padwn_d = PAD_CTR;
        end
      endcase
    end
    game_over_d = state_d == OVER;
  end

  always_ff @(posedge pixel_clock) begin
    if (!reset) begin
      state_q <= SERVE;
      ballx_q <= X_CTR;
      bally_q <= Y_CTR;
      padup_q <= PAD_CTR;
      padwn_q <= PAD_CTR;
      score_up_q <= '0;
      score_dn_q <= '0;
      dx_q <= 3'sd1;
      dy_q <= -3'sd1;
      miss_cnt_q <= '0;
      game_over_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ballx_q <= ballx_d;
      bally_q <= bally_d;
      padup_q <= padup_d;
      padwn_q <= padwn_d;
      score_up_q <= score_up_d;
      score_dn_q <= score_dn_d;
      dx_q <= dx_d;
      dy_q <= dy_d;
      miss_cnt_q <= miss_cnt_d;
      game_over_q <= game_over_d;
    end
  end

  assign ballx = ballx_q;
  assign bally = bally_q;
  assign padup = padup_q;
  assign padwn = padwn_q;
  assign score_up = score_up_q;
  assign score_dn = score_dn_q;
  assign game_over = game_over_q;
endmodule

// File: tb/tb_pong_engine.sv
// tb_pong_engine: scoreboard bench comparing the engine against a per-frame behavioural model
module tb_pong_engine;
  logic pixel_clock = 1'b0;
  logic reset = 1'b0;
  logic [10:0] pixel_count0 = 11'd5;
  logic [9:0] line_count0 = 10'd0;
  logic btn_up_l = 1'b0, btn_up_r = 1'b0, btn_dn_l = 1'b0, btn_dn_r = 1'b0, btn_serve = 1'b0;
  logic [9:0] ballx, padup, padwn;
  logic [8:0] bally;
  logic [3:0] score_up, score_dn;
  logic game_over;

  pong_engine #(.WIN_SCORE(9), .MISS_HOLD(60), .PAD_STEP(2)) dut (
    .pixel_clock (pixel_clock),
    .reset       (reset),
    .pixel_count0(pixel_count0),
    .line_count0 (line_count0),
    .btn_up_l    (btn_up_l),
    .btn_up_r    (btn_up_r),
    .btn_dn_l    (btn_dn_l),
    .btn_dn_r    (btn_dn_r),
    .btn_serve   (btn_serve),
    .ballx       (ballx),
    .bally       (bally),
    .padup       (padup),
    .padwn       (padwn),
    .score_up    (score_up),
    .score_dn    (score_dn),
    .game_over   (game_over)
  );

  always #5 pixel_clock = ~pixel_clock;

  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
    logic [9:0] pu;
    logic [9:0] pd;
    logic [3:0] su;
    logic [3:0] sd;
    logic go;
  } obs_t;
  obs_t exp_q[$];
  int checks = 0, errors = 0;
  int m_x, m_y, m_pu, m_pd, m_su, m_sd, m_dx, m_dy, m_st, m_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int clamp(input int v, input int lo, input int hi);
    return v < lo ? lo : v > hi ? hi : v;
  endfunction

  task automatic model_reset();
    m_x = 128; m_y = 200; m_pu = 104; m_pd = 104; m_su = 0; m_sd = 0;
    m_dx = 1; m_dy = -1; m_st = 0; m_cnt = 0;
  endtask

  // b = {serve, dn_r, dn_l, up_r, up_l}; m_st: 0 serve, 1 play, 2 miss, 3 over
  task automatic model_tick(input logic [4:0] b);
    int nx, ny, pad, off, ndx;
    bit hit;
    if (m_st != 3) begin
      m_pu = clamp(m_pu + 2 * (int'(b[1]) - int'(b[0])), 0, 208);
      m_pd = clamp(m_pd + 2 * (int'(b[3]) - int'(b[2])), 0, 208);
    end
    case (m_st)
      0: if (b[4]) begin m_st = 1; m_dx = 1; end
      1: begin
        nx = m_x + m_dx;
        ny = m_y + m_dy;
        ndx = m_dx;
        pad = m_dy < 0 ? m_pd : m_pu;
        hit = (m_dy < 0 ? (ny <= 20 && m_y > 20) : (ny >= 380 && m_y < 380)) && m_x >= pad && m_x <= pad + 48;
        if (hit) begin
          off = m_x - pad;
          ndx = off < 16 ? -2 : off > 32 ? 2 : (m_dx < 0 ? -1 : 1);
          ny = m_dy < 0 ? 20 : 380;
          m_dy = -m_dy;
        end else if (ny <= 0) begin
          ny = 0; m_su = m_su < 9 ? m_su + 1 : m_su; m_st = 2;
        end else if (ny >= 400) begin
          ny = 400; m_sd = m_sd < 9 ? m_sd + 1 : m_sd; m_st = 2;
        end
        if (nx <= 10 || nx >= 246) begin
          ndx = -m_dx;
          nx = clamp(nx, 10, 246);
        end
        m_x = nx; m_y = ny; m_dx = ndx;
      end
      2: if (m_cnt == 59) begin
        m_cnt = 0;
        if (m_su == 9 || m_sd == 9) m_st = 3;
        else begin m_st = 0; m_x = 128; m_y = 200; end
      end else m_cnt++;
      default: if (b[4]) begin
        m_su = 0; m_sd = 0; m_x = 128; m_y = 200; m_pu = 104; m_pd = 104; m_st = 0;
      end
    endcase
  endtask

  function automatic obs_t model_obs();
    return '{x: 10'(m_x), y: 9'(m_y), pu: 10'(m_pu), pd: 10'(m_pd), su: 4'(m_su), sd: 4'(m_sd), go: m_st == 3};
  endfunction

  task automatic compare();
    obs_t e;
    e = exp_q.pop_front();
    chk("sb_ballx", ballx, e.x);
    chk("sb_bally", bally, e.y);
    chk("sb_padup", padup, e.pu);
    chk("sb_padwn", padwn, e.pd);
    chk("sb_score_up", score_up, e.su);
    chk("sb_score_dn", score_dn, e.sd);
    chk("sb_game_over", game_over, e.go);
  endtask

  task automatic frame(input logic [4:0] b);
    {btn_serve, btn_dn_r, btn_dn_l, btn_up_r, btn_up_l} = b;
    repeat (3) @(negedge pixel_clock);
    line_count0 = 10'd480;
    pixel_count0 = 11'd0;
    model_tick(b);
    exp_q.push_back(model_obs());
    @(posedge pixel_clock);
    #1;
    line_count0 = 10'd0;
    pixel_count0 = 11'd5;
    compare();
  endtask

  task automatic do_reset();
    @(negedge pixel_clock);
    reset = 1'b0;
    line_count0 = 10'd480;
    pixel_count0 = 11'd0;
    @(posedge pixel_clock);
    #1;
    reset = 1'b1;
    line_count0 = 10'd0;
    pixel_count0 = 11'd5;
    model_reset();
  endtask

  task automatic check_home(input string tag);
    chk({tag, "_ballx"}, ballx, 128);
    chk({tag, "_bally"}, bally, 200);
    chk({tag, "_padup"}, padup, 104);
    chk({tag, "_padwn"}, padwn, 104);
    chk({tag, "_scores"}, {score_up, score_dn}, 0);
    chk({tag, "_game_over"}, game_over, 0);
  endtask

  initial begin
    int n;
    do_reset();
    check_home("reset");
    repeat (3) frame(5'b00000);
    check_home("idle");
    frame(5'b10000);
    chk("serve_ballx", ballx, 128);
    chk("serve_bally", bally, 200);
    repeat (20) frame(5'b00000);
    chk("run20_ballx", ballx, 148);
    chk("run20_bally", bally, 180);
    repeat (98) frame(5'b00000);
    chk("wall_ballx", ballx, 246);
    chk("wall_bally", bally, 82);
    frame(5'b00000);
    chk("reflect_ballx", ballx, 245);
    repeat (5) frame(5'b01100);
    chk("both_hold_padwn", padwn, 104);
    repeat (200) frame(5'b01000);
    chk("sat_padwn", padwn, 208);
    chk("miss_score_up", score_up, 1);
    chk("recentre_ballx", ballx, 128);
    chk("recentre_bally", bally, 200);
    @(negedge pixel_clock);
    btn_dn_l = 1'b1;
    @(negedge pixel_clock);
    btn_dn_l = 1'b0;
    frame(5'b00000);
    chk("short_press_padwn", padwn, 208);
    repeat (1500) frame(5'(($urandom_range(0, 3) == 0 ? 16 : 0) | $urandom_range(0, 15)));
    if (m_st == 3) frame(5'b10000);
    n = 0;
    while (m_st != 3 && n < 10000) begin
      frame({m_st == 0, 4'b0101});
      n++;
    end
    chk("over_game_over", game_over, 1);
    chk("over_win_score", score_up == 4'd9 || score_dn == 4'd9, 1);
    repeat (5) frame(5'b00011);
    frame(5'b10000);
    check_home("restart");
    frame(5'b10000);
    repeat (10) frame(5'b00000);
    do_reset();
    check_home("mid_reset");
    repeat (3) frame(5'b00000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
